nco_tone_sequencer: RTL and testbench

//  Schedules the two NCO phase increments feeding the DAC combiner: steps through a programmable

---
 rtl/nco_seq_pkg.sv | 21 ++
 rtl/nco_tone_table.sv | 26 ++
 rtl/nco_tone_sequencer.sv | 152 +++++++++++++++
 tb/tb_nco_tone_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_seq_pkg.sv
// Shared types and default widths for the NCO tone sequencer.
package nco_seq_pkg;

    localparam int PHASE_W = 32;
    localparam int DWELL_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_DWELL,
        ST_DONE
    } seq_state_t;

    typedef struct packed {
        logic [PHASE_W-1:0] phi_a;
        logic [PHASE_W-1:0] phi_b;
        logic [DWELL_W-1:0] dwell;
    } tone_entry_t;

endpackage

// File: rtl/nco_tone_table.sv
// Tone table: DEPTH x tone_entry_t, one write port, one registered read port.
module nco_tone_table
    import nco_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  tone_entry_t   wdata,
    input  logic [AW-1:0] raddr,
    output tone_entry_t   rdata
);

    tone_entry_t mem [DEPTH];

    // No reset, so the array maps onto block RAM and keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/nco_tone_sequencer.sv
// Steps both NCO phase increments through the tone table, muting the DAC while each retune settles.
module nco_tone_sequencer
    import nco_seq_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int AW            = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [PHASE_W-1:0] cfg_phi_a,
    input  logic [PHASE_W-1:0] cfg_phi_b,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AW-1:0]      last_idx,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    output logic [PHASE_W-1:0] phi_inc_a,
    output logic [PHASE_W-1:0] phi_inc_b,
    output logic               dac_mute,
    output logic               busy,
    output logic [AW-1:0]      cur_idx,
    output logic               step,
    output logic               done,
    output logic               cfg_err
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    seq_state_t         state, state_d;
    logic [AW-1:0]      idx, idx_d;
    logic [AW-1:0]      last_q;
    logic               loop_q;
    logic [SW-1:0]      settle_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    tone_entry_t        rd_entry;
    tone_entry_t        wr_entry;
    logic               accept_start;
    logic               mute_d, busy_d, step_d, done_d, err_d;

    assign accept_start = (state == ST_IDLE) && start && !stop;
    assign wr_entry     = '{phi_a: cfg_phi_a, phi_b: cfg_phi_b, dwell: cfg_dwell};

    // Read address is the next index, so the entry is already registered during LOAD.
    nco_tone_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk   (clk),
        .we    (cfg_we && (state == ST_IDLE)),
        .waddr (cfg_addr),
        .wdata (wr_entry),
        .raddr (idx_d),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        unique case (state)
            ST_IDLE: begin
                if (accept_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD:   state_d = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == '0) state_d = ST_DWELL;
            ST_DWELL: begin
                if (dwell_cnt == '0) begin
                    if (idx < last_q) begin
                        idx_d   = idx + 1'b1;
                        state_d = ST_LOAD;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (stop && (state != ST_IDLE)) begin
            state_d = ST_DONE;
            idx_d   = idx;
        end
    end

    always_comb begin
        mute_d = (state_d != ST_DWELL);
        busy_d = (state_d != ST_IDLE);
        step_d = (state_d == ST_DWELL) && (state == ST_SETTLE);
        done_d = (state_d == ST_DONE);
        err_d  = cfg_we && (state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phi_inc_a  <= '0;
            phi_inc_b  <= '0;
            dac_mute   <= 1'b1;
            busy       <= 1'b0;
            cur_idx    <= '0;
            step       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            last_q     <= '0;
            loop_q     <= 1'b0;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
        end else begin
            dac_mute <= mute_d;
            busy     <= busy_d;
            step     <= step_d;
            done     <= done_d;
            cfg_err  <= err_d;
            if (accept_start) begin
                last_q <= last_idx;
                loop_q <= loop_en;
            end
            if ((state == ST_LOAD) && (state_d == ST_SETTLE)) begin
                phi_inc_a  <= rd_entry.phi_a;
                phi_inc_b  <= rd_entry.phi_b;
                cur_idx    <= idx;
                settle_cnt <= SW'(SETTLE_CYCLES - 1);
            end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            // A zero dwell is stretched to a single cycle.
            if ((state == ST_SETTLE) && (state_d == ST_DWELL)) begin
                dwell_cnt <= (rd_entry.dwell == '0) ? '0 : rd_entry.dwell - 1'b1;
            end else if ((state == ST_DWELL) && (dwell_cnt != '0)) begin
                dwell_cnt <= dwell_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nco_tone_sequencer.sv
// Scoreboard bench for nco_tone_sequencer: directed runs plus a random mute-window check.
`timescale 1ns/1ps
module tb_nco_tone_sequencer;

    localparam int S = 8;
    localparam int K_STEP = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    localparam logic [31:0] A0 = 32'h0CCC_CCCD, B0 = 32'h4000_0000;
    localparam logic [31:0] A1 = 32'h1111_1111, B1 = 32'h2222_2222;
    localparam logic [31:0] A2 = 32'h3333_3333, B2 = 32'h4444_4444;
    localparam logic [31:0] AN = 32'hDEAD_BEEF, BN = 32'h0123_4567;

    typedef struct {
        int          kind;
        int unsigned cyc;
        logic [3:0]  idx;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_phi_a = '0, cfg_phi_b = '0;
    logic [23:0] cfg_dwell = '0;
    logic [3:0]  last_idx = '0;
    logic        loop_en = 1'b0, start = 1'b0, stop = 1'b0;
    logic [31:0] phi_inc_a, phi_inc_b;
    logic        dac_mute, busy, step, done, cfg_err;
    logic [3:0]  cur_idx;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          sb_en = 1'b1;
    ev_t         q[$];

    nco_tone_sequencer #(
        .DEPTH         (16),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_phi_a (cfg_phi_a),
        .cfg_phi_b (cfg_phi_b),
        .cfg_dwell (cfg_dwell),
        .last_idx  (last_idx),
        .loop_en   (loop_en),
        .start     (start),
        .stop      (stop),
        .phi_inc_a (phi_inc_a),
        .phi_inc_b (phi_inc_b),
        .dac_mute  (dac_mute),
        .busy      (busy),
        .cur_idx   (cur_idx),
        .step      (step),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int unsigned c, input logic [3:0] i,
                        input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = kind; e.cyc = c; e.idx = i; e.a = a; e.b = b;
        q.push_back(e);
    endtask

    task automatic expect_ev(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d expected none (cyc %0d)", kind, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == K_STEP) begin
                chk("step_cur_idx", {28'h0, cur_idx}, {28'h0, e.idx});
                chk("step_phi_a", phi_inc_a, e.a);
                chk("step_phi_b", phi_inc_b, e.b);
                chk("step_mute", {31'h0, dac_mute}, 32'h0);
            end
        end
    endtask

    // Monitor: every output pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && sb_en) begin
            if (cfg_err) expect_ev(K_ERR);
            if (step)    expect_ev(K_STEP);
            if (done)    expect_ev(K_DONE);
        end
    end

    // Mute must cover every cycle within S cycles of a phase-increment change.
    logic [31:0] pa = '0, pb = '0;
    int          age = 1000;
    always @(negedge clk) begin
        if (phi_inc_a !== pa || phi_inc_b !== pb) age = 0;
        else if (age < 1000) age++;
        pa = phi_inc_a;
        pb = phi_inc_b;
        if (!rst && age < S) begin
            n_cmp++;
            if (dac_mute !== 1'b1) begin
                n_bad++;
                $display("FAIL mute_settle: got mute %0b expected 1, %0d cycles after retune (cyc %0d)",
                         dac_mute, age, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] pha, input logic [31:0] phb,
                      input logic [23:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_phi_a = pha; cfg_phi_b = phb; cfg_dwell = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && q.size() != 0; i++) tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d events still pending expected 0 (cyc %0d)", q.size(), cyc);
            q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned s;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_phi_a", phi_inc_a, 32'h0);
        chk("rst_phi_b", phi_inc_b, 32'h0);
        chk("rst_mute", {31'h0, dac_mute}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_cur_idx", {28'h0, cur_idx}, 32'h0);
        chk("rst_pulses", {29'h0, step, done, cfg_err}, 32'h0);
        rst = 1'b0;
        tick();

        wr(4'd0, A0, B0, 24'd10);
        wr(4'd1, A1, B1, 24'd0);
        wr(4'd2, A2, B2, 24'd5);

        // Reset asserted mid-DWELL takes effect immediately.
        s = cyc; last_idx = 4'd2; loop_en = 1'b1;
        push(K_STEP, s + 10, 4'd0, A0, B0);
        pulse_start();
        wait_until(s + 15);
        #2 rst = 1'b1;
        #1;
        chk("arst_phi_a", phi_inc_a, 32'h0);
        chk("arst_phi_b", phi_inc_b, 32'h0);
        chk("arst_mute", {31'h0, dac_mute}, 32'h1);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        drain(1);
        tick();

        // Single-shot run over entries 0..2; table survived the reset.
        s = cyc; last_idx = 4'd2; loop_en = 1'b0;
        push(K_STEP, s + 10, 4'd0, A0, B0);
        push(K_STEP, s + 29, 4'd1, A1, B1);
        push(K_STEP, s + 39, 4'd2, A2, B2);
        push(K_DONE, s + 44, 4'd0, 32'h0, 32'h0);
        pulse_start();
        tick();
        chk("first_phi_a", phi_inc_a, A0);
        chk("first_phi_b", phi_inc_b, B0);
        chk("first_mute", {31'h0, dac_mute}, 32'h1);
        chk("first_busy", {31'h0, busy}, 32'h1);
        drain(80);
        tick();
        chk("single_idle", {31'h0, busy}, 32'h0);

        // Looped run, ignored restart, stop on entry 1 dwell expiry.
        s = cyc; last_idx = 4'd2; loop_en = 1'b1;
        push(K_STEP, s + 10, 4'd0, A0, B0);
        push(K_STEP, s + 29, 4'd1, A1, B1);
        push(K_STEP, s + 39, 4'd2, A2, B2);
        push(K_STEP, s + 53, 4'd0, A0, B0);
        push(K_STEP, s + 72, 4'd1, A1, B1);
        push(K_DONE, s + 73, 4'd0, 32'h0, 32'h0);
        pulse_start();
        wait_until(s + 20);
        pulse_start();
        wait_until(s + 72);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_mute", {31'h0, dac_mute}, 32'h1);
        chk("stop_phi_a", phi_inc_a, A1);
        chk("stop_phi_b", phi_inc_b, B1);
        chk("stop_cur_idx", {28'h0, cur_idx}, 32'h1);
        drain(10);
        repeat (30) tick();
        chk("loop_idle", {31'h0, busy}, 32'h0);

        // start and stop together in IDLE: nothing happens.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (20) tick();
        chk("startstop_busy", {31'h0, busy}, 32'h0);
        chk("startstop_idx", {28'h0, cur_idx}, 32'h1);

        // Write while busy is dropped and flagged.
        s = cyc; last_idx = 4'd0; loop_en = 1'b0;
        push(K_ERR,  s + 4,  4'd0, 32'h0, 32'h0);
        push(K_STEP, s + 10, 4'd0, A0, B0);
        push(K_DONE, s + 20, 4'd0, 32'h0, 32'h0);
        pulse_start();
        wait_until(s + 3);
        wr(4'd0, AN, BN, 24'd2);
        drain(40);
        tick();
        s = cyc;
        push(K_STEP, s + 10, 4'd0, A0, B0);
        push(K_DONE, s + 20, 4'd0, 32'h0, 32'h0);
        pulse_start();
        drain(40);
        tick();

        // Write in IDLE, start on the very next cycle picks up the new entry.
        wr(4'd0, AN, BN, 24'd2);
        s = cyc;
        push(K_STEP, s + 10, 4'd0, AN, BN);
        push(K_DONE, s + 12, 4'd0, 32'h0, 32'h0);
        pulse_start();
        drain(40);
        tick();

        // Random start/stop traffic; only the mute-window check is active.
        sb_en = 1'b0;
        for (int i = 0; i < 800; i++) begin
            start    = ($urandom_range(7) == 0);
            stop     = ($urandom_range(40) == 0);
            last_idx = 4'($urandom_range(2));
            loop_en  = 1'($urandom_range(1));
            tick();
        end
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        repeat (5) tick();
        sb_en = 1'b1;
        chk("random_end_idle", {31'h0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
